// File: rtl/pipe_stage_reg.sv
// pipe_stage_reg: valid/ready pipeline register with optional skid entry, flush and saturating stall/bubble counters
module pipe_stage_reg #(
  parameter int DATA_W = 32,
  parameter int CTRL_W = 8,
  parameter int SKID = 1,
  parameter int CNT_W = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic              flush,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [CNT_W-1:0]  stall_cnt,
  output logic [CNT_W-1:0]  bubble_cnt,
  input  logic              clr_cnt
);
  logic              main_v;
  logic [DATA_W-1:0] main_data;
  logic [CTRL_W-1:0] main_ctrl;
  logic              accept;
  logic              consume;
  assign accept    = in_valid & in_ready;
  assign consume   = main_v & out_ready;
  assign out_valid = main_v;
  assign out_data  = main_data;
  assign out_ctrl  = main_v ? main_ctrl : '0;
  if (SKID == 0) begin : g_single
    assign in_ready = ~main_v | out_ready;
    always_ff @(posedge clk or negedge reset)
      if (!reset) begin
        main_v    <= 1'b0;
        main_data <= '0;
        main_ctrl <= '0;
      end else if (flush) begin
        main_v    <= 1'b0;
        main_ctrl <= '0;
      end else if (in_ready) begin
        main_v <= in_valid;
        if (in_valid) begin
          main_data <= in_data;
          main_ctrl <= in_ctrl;
        end
      end
  end else begin : g_skid
    logic              skid_v;
    logic              rdy;
    logic [DATA_W-1:0] skid_data;
    logic [CTRL_W-1:0] skid_ctrl;
    assign in_ready = rdy;
    always_ff @(posedge clk or negedge reset)
      if (!reset) begin
        main_v    <= 1'b0;
        main_data <= '0;
        main_ctrl <= '0;
        skid_v    <= 1'b0;
        skid_data <= '0;
        skid_ctrl <= '0;
        rdy       <= 1'b1;
      end else if (flush) begin
        main_v    <= 1'b0;
        main_ctrl <= '0;
        skid_v    <= 1'b0;
        rdy       <= 1'b1;
      end else if (consume | ~main_v) begin
        if (skid_v) begin
          main_data <= skid_data;
          main_ctrl <= skid_ctrl;
          skid_v    <= 1'b0;
          rdy       <= 1'b1;
        end else begin
          main_v <= accept;
          if (accept) begin
            main_data <= in_data;
            main_ctrl <= in_ctrl;
          end
        end
      end else if (accept) begin
        skid_data <= in_data;
        skid_ctrl <= in_ctrl;
        skid_v    <= 1'b1;
        rdy       <= 1'b0;
      end
  end
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      stall_cnt  <= '0;
      bubble_cnt <= '0;
    end else if (clr_cnt) begin
      stall_cnt  <= '0;
      bubble_cnt <= '0;
    end else begin
      if (main_v & ~out_ready & ~&stall_cnt) stall_cnt <= stall_cnt + 1'b1;
      if (~main_v & out_ready & ~&bubble_cnt) bubble_cnt <= bubble_cnt + 1'b1;
    end
endmodule

// File: tb/tb_pipe_stage_reg.sv
// tb_pipe_stage_reg: queue-model check of skid and non-skid builds of pipe_stage_reg
module tb_pipe_stage_reg;
  logic clk = 1'b0;
  logic reset = 1'b0;
  logic in_valid = 1'b0, flush = 1'b0, out_ready = 1'b0, clr_cnt = 1'b0;
  logic [31:0] in_data = '0;
  logic [7:0] in_ctrl = '0;
  logic rdy0, ov0, rdy1, ov1;
  logic [31:0] od0, od1;
  logic [7:0] oc0, oc1;
  logic [15:0] sc0, bc0;
  logic [3:0] sc1, bc1;
  logic [39:0] q0[$];
  logic [39:0] q1[$];
  int st0, bu0, st1, bu1;
  int n_checks = 0;
  int n_fail = 0;
  always #5 clk = ~clk;
  pipe_stage_reg #(.DATA_W(32), .CTRL_W(8), .SKID(0), .CNT_W(16)) u0 (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(rdy0), .in_data(in_data), .in_ctrl(in_ctrl),
    .flush(flush), .out_valid(ov0), .out_ready(out_ready), .out_data(od0), .out_ctrl(oc0),
    .stall_cnt(sc0), .bubble_cnt(bc0), .clr_cnt(clr_cnt));
  pipe_stage_reg #(.DATA_W(32), .CTRL_W(8), .SKID(1), .CNT_W(4)) u1 (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(rdy1), .in_data(in_data), .in_ctrl(in_ctrl),
    .flush(flush), .out_valid(ov1), .out_ready(out_ready), .out_data(od1), .out_ctrl(oc1),
    .stall_cnt(sc1), .bubble_cnt(bc1), .clr_cnt(clr_cnt));
  wire [73:0] got0 = {ov0, rdy0, ov0 ? od0 : 32'h0, oc0, sc0, bc0};
  wire [49:0] got1 = {ov1, rdy1, ov1 ? od1 : 32'h0, oc1, sc1, bc1};
  function automatic logic [73:0] exp0();
    logic [39:0] h = q0.size() > 0 ? q0[0] : 40'h0;
    return {q0.size() > 0, q0.size() == 0 || out_ready, h, st0[15:0], bu0[15:0]};
  endfunction
  function automatic logic [49:0] exp1();
    logic [39:0] h = q1.size() > 0 ? q1[0] : 40'h0;
    return {q1.size() > 0, q1.size() < 2, h, st1[3:0], bu1[3:0]};
  endfunction
  task automatic model_reset();
    q0.delete();
    q1.delete();
    st0 = 0; bu0 = 0; st1 = 0; bu1 = 0;
  endtask
  task automatic tick();
    bit a0, a1, c0, c1;
    a0 = in_valid && (q0.size() == 0 || out_ready);
    a1 = in_valid && q1.size() < 2;
    c0 = q0.size() > 0 && out_ready;
    c1 = q1.size() > 0 && out_ready;
    @(posedge clk);
    if (!reset) model_reset();
    else begin
      if (clr_cnt) begin st0 = 0; bu0 = 0; st1 = 0; bu1 = 0; end
      else begin
        if (q0.size() > 0 && !out_ready && st0 < 65535) st0++;
        if (q0.size() == 0 && out_ready && bu0 < 65535) bu0++;
        if (q1.size() > 0 && !out_ready && st1 < 15) st1++;
        if (q1.size() == 0 && out_ready && bu1 < 15) bu1++;
      end
      if (flush) begin q0.delete(); q1.delete(); end
      else begin
        if (c0) void'(q0.pop_front());
        if (c1) void'(q1.pop_front());
        if (a0) q0.push_back({in_data, in_ctrl});
        if (a1) q1.push_back({in_data, in_ctrl});
      end
    end
    #1;
  endtask
  task automatic test_reset();
    reset = 1'b0;
    model_reset();
    tick();
    tick();
    n_checks++;
    if ({ov1, rdy1, oc1, sc1, bc1} !== {1'b0, 1'b1, 8'h0, 4'h0, 4'h0}) begin
      n_fail++; $display("FAIL reset_u1 got=%h exp=%h", {ov1, rdy1, oc1, sc1, bc1}, {1'b0, 1'b1, 8'h0, 4'h0, 4'h0});
    end
    n_checks++;
    if (got0 !== exp0()) begin n_fail++; $display("FAIL reset_u0 got=%h exp=%h", got0, exp0()); end
    reset = 1'b1;
  endtask
  task automatic test_stream();
    out_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1; in_data = 32'h100 + i; in_ctrl = 8'(i + 1);
      tick();
      n_checks++;
      if ({ov1, od1, rdy1} !== {1'b1, 32'h100 + i, 1'b1}) begin
        n_fail++; $display("FAIL stream_u1 got=%h exp=%h", {ov1, od1, rdy1}, {1'b1, 32'h100 + i, 1'b1});
      end
      n_checks++;
      if (got0 !== exp0()) begin n_fail++; $display("FAIL stream_u0 got=%h exp=%h", got0, exp0()); end
    end
    in_valid = 1'b0;
    tick();
    n_checks++;
    if (got1 !== exp1() || sc1 !== 4'h0) begin n_fail++; $display("FAIL stream_end got=%h exp=%h", got1, exp1()); end
  endtask
  task automatic test_backpressure();
    out_ready = 1'b0;
    in_valid = 1'b1; in_data = 32'hA; in_ctrl = 8'h5A;
    tick();
    in_data = 32'hB; in_ctrl = 8'h5B;
    tick();
    in_valid = 1'b0;
    n_checks++;
    if ({rdy1, ov1, od1} !== {1'b0, 1'b1, 32'hA}) begin
      n_fail++; $display("FAIL bp_full got=%h exp=%h", {rdy1, ov1, od1}, {1'b0, 1'b1, 32'hA});
    end
    tick();
    n_checks++;
    if (got1 !== exp1()) begin n_fail++; $display("FAIL bp_hold got=%h exp=%h", got1, exp1()); end
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      n_checks++;
      if (got1 !== exp1()) begin n_fail++; $display("FAIL bp_drain_u1 got=%h exp=%h", got1, exp1()); end
      n_checks++;
      if (got0 !== exp0()) begin n_fail++; $display("FAIL bp_drain_u0 got=%h exp=%h", got0, exp0()); end
    end
  endtask
  task automatic test_flush();
    out_ready = 1'b0;
    in_valid = 1'b1; in_data = 32'hA; tick();
    in_data = 32'hB; tick();
    flush = 1'b1; in_data = 32'hC; tick();
    flush = 1'b0; in_valid = 1'b0;
    n_checks++;
    if ({ov1, oc1, rdy1} !== {1'b0, 8'h0, 1'b1}) begin
      n_fail++; $display("FAIL flush_u1 got=%h exp=%h", {ov1, oc1, rdy1}, {1'b0, 8'h0, 1'b1});
    end
    n_checks++;
    if ({ov0, oc0} !== {1'b0, 8'h0}) begin n_fail++; $display("FAIL flush_u0 got=%h exp=%h", {ov0, oc0}, 9'h0); end
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      n_checks++;
      if (got1 !== exp1() || ov1 !== 1'b0) begin n_fail++; $display("FAIL flush_after got=%h exp=%h", got1, exp1()); end
    end
  endtask
  task automatic test_async_reset();
    out_ready = 1'b0;
    in_valid = 1'b1; in_data = 32'h11; tick();
    in_data = 32'h22; tick();
    in_valid = 1'b0; tick();
    #2;
    reset = 1'b0;
    #1;
    model_reset();
    n_checks++;
    if ({ov1, rdy1, sc1, bc1} !== {1'b0, 1'b1, 8'h0}) begin
      n_fail++; $display("FAIL async_reset_u1 got=%h exp=%h", {ov1, rdy1, sc1, bc1}, {1'b0, 1'b1, 8'h0});
    end
    n_checks++;
    if (got0 !== exp0()) begin n_fail++; $display("FAIL async_reset_u0 got=%h exp=%h", got0, exp0()); end
    tick();
    reset = 1'b1;
  endtask
  task automatic test_saturation();
    out_ready = 1'b0;
    in_valid = 1'b1; in_data = 32'h33; tick();
    in_valid = 1'b0;
    for (int i = 0; i < 20; i++) tick();
    n_checks++;
    if (sc1 !== 4'hF || got1 !== exp1()) begin n_fail++; $display("FAIL sat_hold got=%h exp=%h", got1, exp1()); end
    n_checks++;
    if (got0 !== exp0()) begin n_fail++; $display("FAIL sat_u0 got=%h exp=%h", got0, exp0()); end
    clr_cnt = 1'b1; tick(); clr_cnt = 1'b0;
    n_checks++;
    if ({sc1, sc0} !== 20'h0) begin n_fail++; $display("FAIL sat_clr got=%h exp=%h", {sc1, sc0}, 20'h0); end
  endtask
  task automatic test_skid0();
    flush = 1'b1; tick(); flush = 1'b0;
    out_ready = 1'b0;
    in_valid = 1'b1; in_data = 32'h40; tick();
    n_checks++;
    if ({ov0, rdy0} !== 2'b10) begin n_fail++; $display("FAIL skid0_stall got=%b exp=10", {ov0, rdy0}); end
    out_ready = 1'b1;
    #1;
    n_checks++;
    if (rdy0 !== 1'b1) begin n_fail++; $display("FAIL skid0_comb got=%b exp=1", rdy0); end
    for (int i = 1; i < 5; i++) begin
      in_data = 32'h40 + i; in_ctrl = 8'(i);
      tick();
      n_checks++;
      if ({ov0, od0, rdy0} !== {1'b1, 32'h40 + i, 1'b1}) begin
        n_fail++; $display("FAIL skid0_b2b got=%h exp=%h", {ov0, od0, rdy0}, {1'b1, 32'h40 + i, 1'b1});
      end
    end
    in_valid = 1'b0;
    tick();
  endtask
  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      in_valid = $urandom_range(0, 9) < 7;
      out_ready = $urandom_range(0, 9) < 6;
      flush = $urandom_range(0, 99) < 3;
      clr_cnt = $urandom_range(0, 99) < 2;
      in_data = $urandom;
      in_ctrl = 8'($urandom);
      tick();
      n_checks++;
      if (got1 !== exp1()) begin n_fail++; $display("FAIL random_u1 cyc=%0d got=%h exp=%h", i, got1, exp1()); end
      n_checks++;
      if (got0 !== exp0()) begin n_fail++; $display("FAIL random_u0 cyc=%0d got=%h exp=%h", i, got0, exp0()); end
    end
    in_valid = 1'b0; flush = 1'b0; clr_cnt = 1'b0;
  endtask
  initial begin
    test_reset();
    test_stream();
    test_backpressure();
    test_flush();
    test_async_reset();
    test_saturation();
    test_skid0();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/pipe_stage_reg.md
Name: pipe_stage_reg

Overview:
- Generic inter-stage pipeline register for the five-stage CPU; replaces the per-stage fixed register files (D/E, E/M, M/W) with one parametrised block.
- Carries a data bus plus a control bus per instruction.
- Adds a valid/ready handshake, an optional 2-entry skid buffer, synchronous flush (bubble insertion) and saturating stall/bubble performance counters.

Parameters:
- DATA_W, 32, width of the payload bus (ALU result, memory read data, PC+4, ...).
- CTRL_W, 8, width of the control bus (RegWrite, MemtoReg, link flags, dest reg, ...).
- SKID, 1, 0: single entry with combinational in_ready; 1: two entries (main + skid) with registered in_ready.
- CNT_W, 16, width of the performance counters.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- in_valid  in  1  upstream stage presents an instruction.
- in_ready  out  1  this stage accepts the instruction this cycle.
- in_data  in  DATA_W  upstream payload.
- in_ctrl  in  CTRL_W  upstream control.
- flush  in  1  synchronous kill of all held instructions.
- out_valid  out  1  downstream sees a valid instruction.
- out_ready  in  1  downstream consumes this cycle.
- out_data  out  DATA_W  payload of the head entry.
- out_ctrl  out  CTRL_W  control of the head entry; all-zero when out_valid=0.
- stall_cnt  out  CNT_W  cycles with out_valid=1 and out_ready=0.
- bubble_cnt  out  CNT_W  cycles with out_valid=0 and out_ready=1.
- clr_cnt  in  1  synchronous clear of both counters.

Behaviour:
- Reset (reset=0, asynchronous): all valid bits, out_data, out_ctrl, the skid entry, stall_cnt and bubble_cnt go to 0. For SKID=1, in_ready=1 immediately. Reset mid-transfer discards all contents.
- Handshakes:
  - Transfer in occurs when in_valid & in_ready; transfer out occurs when out_valid & out_ready.
  - Once out_valid=1, out_data and out_ctrl are stable until consumed or flushed.
- SKID=0:
  - in_ready = ~out_valid | out_ready (combinational).
  - Accepted data appears on out_* one cycle after acceptance (latency 1).
- SKID=1, three states:
  - EMPTY: main invalid, skid invalid; in_ready=1.
  - ONE: main valid, skid invalid; in_ready=1.
  - TWO: both valid; in_ready=0.
- SKID=1 transitions:
  - EMPTY + accept -> ONE.
  - ONE + accept + no consume -> TWO (new entry goes to skid).
  - ONE + accept + consume -> ONE (main reloads from in_*).
  - ONE + consume only -> EMPTY.
  - TWO + consume -> ONE (skid moves to main).
  - in_ready is a registered signal: 1 in EMPTY/ONE, 0 in TWO. Latency 1 when not stalled.
- Ordering: strict FIFO; no instruction is dropped or duplicated except by flush.
- Flush:
  - Highest priority among synchronous events.
  - At the edge, all valid bits clear, out_ctrl clears to 0, the state goes to EMPTY, and in_ready=1 next cycle.
  - An in_valid presented in the flush cycle is discarded. A consume in the flush cycle still counts as consumed downstream.
- Counters:
  - Increment by 1 per qualifying cycle and saturate at 2^CNT_W-1; no wrap.
  - clr_cnt takes priority over increment.
  - Flush cycles are evaluated against the pre-edge out_valid.
- Arithmetic: no width conversion; data and ctrl pass bit-exact.

Test Plan:
- Reset then stream: reset low for 2 cycles, then in_valid=1 with data 0x100..0x104, out_ready=1 -> out_data 0x100..0x104 each one cycle after acceptance, in_ready constant 1, stall_cnt=0.
- Backpressure (SKID=1): send 0xA, 0xB with out_ready=0 -> state TWO, in_ready=0 after the 2nd accept, out_data holds 0xA; raise out_ready -> 0xA then 0xB appear, in_ready back to 1, stall_cnt=2 (or the actual number of stalled cycles).
- Flush while full: state TWO holding 0xA, 0xB, pulse flush with in_valid=1 data 0xC -> next cycle out_valid=0, out_ctrl=0, in_ready=1; 0xA, 0xB, 0xC never appear.
- Async reset mid-stall: state TWO, drop reset between clock edges -> out_valid, in_ready(SKID=1 -> 1), and the counters change without waiting for clk.
- Counter saturation: CNT_W=4, out_valid=1, out_ready=0 for 20 cycles -> stall_cnt reaches 15 and holds; clr_cnt=1 -> 0 next cycle.
- SKID=0 build: out_ready=0 with out_valid=1 -> in_ready=0 in the same cycle; out_ready=1 -> in_ready=1 in the same cycle, and simultaneous accept plus consume sustains 1 instruction per cycle.
